// File: rtl/serial_pattern_tx_if.sv
// Serial frame transmitter bus: frame request/payload in, serial bit and
// handshake/debug status out.
interface serial_pattern_tx_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] data;
  logic             a_out;
  logic             busy;
  logic             done;
  logic [CW-1:0]    bit_cnt;

  // Transmitter side
  modport slave (
    input  start,
    input  data,
    output a_out,
    output busy,
    output done,
    output bit_cnt
  );

  // Controller / testbench side
  modport master (
    output start,
    output data,
    input  a_out,
    input  busy,
    input  done,
    input  bit_cnt
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial frame transmitter: start bit (1), WIDTH payload bits MSB first,
// stop bit (0). Back-to-back frames are accepted from the STOP state.
module serial_pattern_tx #(
  parameter int unsigned WIDTH = 8
) (
  input logic                 clk,
  input logic                 reset,
  serial_pattern_tx_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_out_q, a_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // State, shifter and registered outputs; reset discards any partial frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      a_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      a_out_q <= a_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they can be
  // registered without adding a cycle of latency
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d = bus.data;
          cnt_d   = CW'(WIDTH);
          state_d = START;
        end
      end
      START: begin
        state_d = DATA;
      end
      DATA: begin
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bus.start) begin
          shift_d = bus.data;
          cnt_d   = CW'(WIDTH);
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    a_out_d = (state_d == START) || ((state_d == DATA) && shift_d[WIDTH-1]);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == STOP);
  end

  assign bus.a_out   = a_out_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bit_cnt = cnt_q;
endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: WIDTH=8 and WIDTH=4 instances share clock and
// reset; expected per-cycle outputs are queued as stimulus is applied and
// popped one per clock.
module tb_serial_pattern_tx;
  localparam int unsigned W8 = 8;
  localparam int unsigned W4 = 4;

  typedef struct {
    logic       a;
    logic       b;
    logic       d;
    logic [3:0] cnt;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_pattern_tx_if #(.WIDTH(W8)) bus8 ();
  serial_pattern_tx_if #(.WIDTH(W4)) bus4 ();

  serial_pattern_tx #(.WIDTH(W8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  serial_pattern_tx #(.WIDTH(W4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  exp_t q8[$];
  exp_t q4[$];
  int   errors = 0;
  int   checks = 0;
  vec_t tbl[4];

  function automatic exp_t idle_e();
    exp_t e;
    e.a = 1'b0; e.b = 1'b0; e.d = 1'b0; e.cnt = 4'd0;
    return e;
  endfunction

  // Expected outputs for cycle i (0 = start bit) of a frame of width w
  function automatic exp_t frame_e(input logic [9:0] bits, input int w, input int i);
    exp_t e;
    e.a = bits[w + 1 - i];
    e.b = 1'b1;
    e.d = (i == w + 1);
    if (i == 0)      e.cnt = 4'(w);
    else if (i <= w) e.cnt = 4'(w - i + 1);
    else             e.cnt = 4'd0;
    return e;
  endfunction

  task automatic push8_frame(input logic [9:0] bits, input int n);
    for (int i = 0; i < n; i++) q8.push_back(frame_e(bits, W8, i));
  endtask

  task automatic cmp(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got a/busy/done/cnt=%b required %b", name, got, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge
  task automatic step(input string name);
    exp_t e;
    @(posedge clk);
    #1;
    if (q8.size() > 0) begin
      e = q8.pop_front();
      cmp({name, "/w8"}, {bus8.a_out, bus8.busy, bus8.done, bus8.bit_cnt},
          {e.a, e.b, e.d, e.cnt});
    end
    if (q4.size() > 0) begin
      e = q4.pop_front();
      cmp({name, "/w4"}, {bus4.a_out, bus4.busy, bus4.done, 1'b0, bus4.bit_cnt},
          {e.a, e.b, e.d, e.cnt});
    end
  endtask

  initial begin
    tbl[0] = '{data: 8'hA5, bits: 10'b1_10100101_0, name: "frame_a5"};
    tbl[1] = '{data: 8'hFF, bits: 10'b1_11111111_0, name: "frame_ff"};
    tbl[2] = '{data: 8'h00, bits: 10'b1_00000000_0, name: "frame_00"};
    tbl[3] = '{data: 8'h81, bits: 10'b1_10000001_0, name: "frame_81"};

    reset = 1'b1;
    bus8.start = 1'b0; bus8.data = '0;
    bus4.start = 1'b0; bus4.data = '0;

    // Reset asserted with start high: nothing may leave IDLE
    #1;
    reset = 1'b0;
    bus8.start = 1'b1;
    bus8.data  = 8'hA5;
    bus4.start = 1'b1;
    bus4.data  = 4'hF;
    repeat (3) begin
      q8.push_back(idle_e());
      q4.push_back(idle_e());
      step("reset_hold");
    end
    reset = 1'b1;
    bus8.start = 1'b0;
    bus4.start = 1'b0;
    q8.push_back(idle_e());
    q4.push_back(idle_e());
    step("post_reset_idle");

    // Single frames from the vector table
    for (int k = 0; k < 4; k++) begin
      bus8.data  = tbl[k].data;
      bus8.start = 1'b1;
      push8_frame(tbl[k].bits, W8 + 2);
      step(tbl[k].name);
      bus8.start = 1'b0;
      bus8.data  = ~tbl[k].data;
      repeat (W8 + 1) step(tbl[k].name);
      q8.push_back(idle_e());
      step({tbl[k].name, "_idle"});
    end

    // Back-to-back: FF then 00 loaded at the first STOP, no gap
    bus8.data  = 8'hFF;
    bus8.start = 1'b1;
    push8_frame(10'b1_11111111_0, W8 + 2);
    push8_frame(10'b1_00000000_0, W8 + 2);
    repeat (W8 + 2) step("b2b_ff");
    bus8.data = 8'h00;
    step("b2b_00");
    bus8.start = 1'b0;
    bus8.data  = 8'hFF;
    repeat (W8 + 1) step("b2b_00");
    q8.push_back(idle_e());
    step("b2b_idle");

    // start during DATA is ignored; no second frame follows
    bus8.data  = 8'hA5;
    bus8.start = 1'b1;
    push8_frame(10'b1_10100101_0, W8 + 2);
    q8.push_back(idle_e());
    q8.push_back(idle_e());
    step("ign_start");
    bus8.start = 1'b0;
    repeat (3) step("ign_start");
    bus8.start = 1'b1;
    bus8.data  = 8'h3C;
    step("ign_start");
    bus8.start = 1'b0;
    repeat (W8 - 2 + 2) step("ign_start");

    // Mid-frame reset during the 4th payload bit
    bus8.data  = 8'hA5;
    bus8.start = 1'b1;
    push8_frame(10'b1_10100101_0, 5);
    step("mid_rst_pre");
    bus8.start = 1'b0;
    repeat (4) step("mid_rst_pre");
    reset = 1'b0;
    #1;
    cmp("mid_rst_async", {bus8.a_out, bus8.busy, bus8.done, bus8.bit_cnt}, 7'd0);
    q8.push_back(idle_e());
    q8.push_back(idle_e());
    repeat (2) step("mid_rst_hold");
    reset = 1'b1;
    q8.push_back(idle_e());
    step("mid_rst_release");
    bus8.data  = 8'h81;
    bus8.start = 1'b1;
    push8_frame(10'b1_10000001_0, W8 + 2);
    step("fresh_frame");
    bus8.start = 1'b0;
    repeat (W8 + 1) step("fresh_frame");
    q8.push_back(idle_e());
    step("fresh_idle");

    // WIDTH=4 instance, payload 1001
    bus4.data  = 4'b1001;
    bus4.start = 1'b1;
    for (int i = 0; i < 6; i++) q4.push_back(frame_e(10'b0000_110010, W4, i));
    q4.push_back(idle_e());
    step("w4_frame");
    bus4.start = 1'b0;
    repeat (6) step("w4_frame");

    cmp("queues_drained", {5'd0, q8.size() == 0, q4.size() == 0}, 7'b0000011);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
Serial frame transmitter. It drives the single-bit serial input stream consumed by the lab's serial FSM receivers/detectors. A WIDTH-bit word is loaded on a start request and shifted out MSB first, framed by one start bit (1) and one stop bit (0). A busy/done handshake lets a controller or testbench chain frames back-to-back without idle gaps.

Parameters:
WIDTH, 8, number of payload bits per frame (legal 2..32)

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  frame request; sampled at rising clk only in IDLE or STOP state
data  input  WIDTH  payload word; captured on the same edge that accepts start
a_out  output  1  registered serial output bit
busy  output  1  1 while a frame is in progress (START, DATA, STOP states)
done  output  1  one-cycle pulse, high during the cycle the stop bit is driven
bit_cnt  output  $clog2(WIDTH+1)  payload bits remaining, debug/observability

Behaviour:
- Reset (reset=0, async): state=IDLE, shift register=0, bit_cnt=0, a_out=0, busy=0, done=0. Held while reset=0; the first edge after release behaves as IDLE.
- All outputs are registered. No combinational path from start/data to any output.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - a_out=0, busy=0, done=0.
  - start=1 at an edge -> capture data into shift reg, bit_cnt=WIDTH, go to START.
  - start=0 -> stay in IDLE.
- START (1 cycle): a_out=1, busy=1. Next edge -> DATA.
- DATA (WIDTH cycles):
  - a_out = shift_reg[WIDTH-1] (MSB first).
  - Each edge shifts left by 1 (zero fill) and decrements bit_cnt.
  - After WIDTH bits, i.e. the edge where bit_cnt goes 1->0, -> STOP.
- STOP (1 cycle): a_out=0, busy=1, done=1. Next edge:
  - start=1 -> capture new data and go straight to START (back-to-back, zero idle cycles).
  - else -> IDLE (busy=0, done=0).
- Frame length is exactly WIDTH+2 cycles. The start bit appears on a_out the cycle after the accepting edge (1-cycle latency).
- start while in START or DATA is ignored. Frames in progress are never aborted or restarted, and data changes during a frame have no effect.
- start held high continuously -> continuous frames, each with period WIDTH+2.
- Asserting reset mid-frame immediately forces a_out=0, busy=0, done=0. The partial frame is discarded and is not resumed after release.
- bit_cnt reads WIDTH during START, WIDTH..1 during DATA, and 0 in STOP/IDLE.

Test Plan:
- Reset check: drive reset=0 at t=1 with start=1 -> a_out=0, busy=0, done=0, bit_cnt=0 while held. No frame starts until reset=1 and start is sampled at a clock edge.
- Single frame, WIDTH=8, data=8'hA5, start pulsed 1 cycle -> a_out over the next 10 cycles = 1,1,0,1,0,0,1,0,1,0. busy high all 10 cycles; done high only in cycle 10; then IDLE with a_out=0.
- Back-to-back: start held high with data=8'hFF, then data=8'h00 at the first STOP -> frames 1,11111111,0 then 1,00000000,0 with no gap. busy stays 1 for 20 cycles; done pulses at cycles 10 and 20.
- Ignored start: start pulse and data=8'h3C during the DATA phase of an 8'hA5 frame -> the A5 frame is unchanged and the state returns to IDLE afterwards (no second frame).
- Mid-frame reset: reset=0 during the 4th payload bit of 8'hA5 -> outputs 0 immediately. A new start after release sends a complete fresh frame from its start bit.
- Parameter check WIDTH=4, data=4'b1001 -> a_out = 1,1,0,0,1,0 (6 cycles), with done in the 6th cycle.
